// File: rtl/serial_comp.sv
// Serial magnitude comparator: walks the operands chunk by chunk from the MSB end and stops at the first differing chunk.
// Optional signed mode is enabled by defining SERIAL_COMP_SIGNED_EN, which adds the sgn input.
module serial_comp #(
    parameter int bits  = 16,
    parameter int chunk = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [bits-1:0] in1,
    input  logic [bits-1:0] in2,
`ifdef SERIAL_COMP_SIGNED_EN
    input  logic            sgn,
`endif
    output logic            busy,
    output logic            done,
    output logic            Lt,
    output logic            Gt,
    output logic            Et
);

    localparam int NCH = bits / chunk;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0]  IDX_TOP  = IW'(NCH - 1);
    localparam logic [IW-1:0]  IDX_ZERO = IW'(0);
    localparam logic [IW-1:0]  IDX_ONE  = IW'(1);
    localparam logic [chunk:0] MSB_WIDE = {1'b1, {chunk{1'b0}}};
    localparam logic [chunk-1:0] MSB_MASK = MSB_WIDE[chunk:1];

    generate
        if ((bits % chunk) != 0) begin : g_bad_chunk
            $error("serial_comp: bits must be an integer multiple of chunk");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [bits-1:0]   a_r;
    logic [bits-1:0]   b_r;
    logic [IW-1:0]     idx;
    logic [bits-1:0]   a_sh;
    logic [bits-1:0]   b_sh;
    logic [chunk-1:0]  ca;
    logic [chunk-1:0]  cb;
    logic              flip;
`ifdef SERIAL_COMP_SIGNED_EN
    logic              sgn_r;
`endif

    // Select the current chunk; signed mode flips the sign bit of the top chunk only
    always_comb begin
        a_sh = a_r >> (int'(idx) * chunk);
        b_sh = b_r >> (int'(idx) * chunk);
`ifdef SERIAL_COMP_SIGNED_EN
        flip = sgn_r && (idx == IDX_TOP);
`else
        flip = 1'b0;
`endif
        if (flip) begin
            ca = a_sh[chunk-1:0] ^ MSB_MASK;
            cb = b_sh[chunk-1:0] ^ MSB_MASK;
        end else begin
            ca = a_sh[chunk-1:0];
            cb = b_sh[chunk-1:0];
        end
    end

    // Control FSM with registered status and result flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= {bits{1'b0}};
            b_r   <= {bits{1'b0}};
            idx   <= IDX_ZERO;
            busy  <= 1'b0;
            done  <= 1'b0;
            Lt    <= 1'b0;
            Gt    <= 1'b0;
            Et    <= 1'b0;
`ifdef SERIAL_COMP_SIGNED_EN
            sgn_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= in1;
                        b_r   <= in2;
`ifdef SERIAL_COMP_SIGNED_EN
                        sgn_r <= sgn;
`endif
                        Lt    <= 1'b0;
                        Gt    <= 1'b0;
                        Et    <= 1'b0;
                        idx   <= IDX_TOP;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (ca != cb) begin
                        Lt    <= (ca < cb);
                        Gt    <= (ca > cb);
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (idx == IDX_ZERO) begin
                        Et    <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx - IDX_ONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comp.sv
// Directed self-checking bench for serial_comp (bits=16, chunk=4).
module tb_serial_comp;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        busy;
    logic        done;
    logic        Lt;
    logic        Gt;
    logic        Et;
`ifdef SERIAL_COMP_SIGNED_EN
    logic        sgn;
`endif

    int total = 0;
    int bad   = 0;

    serial_comp #(.bits(16), .chunk(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .in1  (in1),
        .in2  (in2),
`ifdef SERIAL_COMP_SIGNED_EN
        .sgn  (sgn),
`endif
        .busy (busy),
        .done (done),
        .Lt   (Lt),
        .Gt   (Gt),
        .Et   (Et)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic b, input logic d,
                               input logic l, input logic g, input logic e);
        check({tag, ".flags"}, {27'd0, busy, done, Lt, Gt, Et}, {27'd0, b, d, l, g, e});
    endtask

    // Count edges until done is seen, bounded
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 10);
    endtask

    // One compare: accept, count latency, verify result and return to IDLE
    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input int em, input logic el, input logic eg, input logic ee);
        int n;
        @(negedge clk);
        in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_flags({tag, ".run"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done(n);
        check({tag, ".lat"}, n, em);
        check_flags({tag, ".done"}, 1'b1, 1'b1, el, eg, ee);
        @(posedge clk); #1;
        check_flags({tag, ".idle"}, 1'b0, 1'b0, el, eg, ee);
    endtask

    initial begin
        int n;
        int n2;
        rst = 1'b1; start = 1'b0; in1 = 16'h0000; in2 = 16'h0000;
`ifdef SERIAL_COMP_SIGNED_EN
        sgn = 1'b0;
`endif
        @(negedge clk);
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        run("eq", 16'h1234, 16'h1234, 4, 1'b0, 1'b0, 1'b1);
        run("msb_gt", 16'h8000, 16'h7FFF, 1, 1'b0, 1'b1, 1'b0);
`ifdef SERIAL_COMP_SIGNED_EN
        sgn = 1'b1;
        run("msb_signed", 16'h8000, 16'h7FFF, 1, 1'b1, 1'b0, 1'b0);
        sgn = 1'b0;
`endif

        // Operand change after acceptance must not matter
        @(negedge clk);
        in1 = 16'h12A4; in2 = 16'h12B4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in1 = 16'hFFFF;
        wait_done(n);
        check("chg.lat", n, 3);
        check_flags("chg.done", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Start re-pulsed during RUN must be ignored
        @(negedge clk);
        in1 = 16'h0005; in2 = 16'h0003; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        in1 = 16'h0000; in2 = 16'hF000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n2);
        check("ign.lat", n2 + 2, 4);
        check_flags("ign.done", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_flags("ign.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        in1 = 16'hAAAA; in2 = 16'hAAAA; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check_flags("rst.pre", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check_flags("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy) n++;
        end
        check("rst.nodone", n, 0);
        run("post_rst", 16'h0000, 16'h0001, 4, 1'b1, 1'b0, 1'b0);

        // Start held high: back-to-back compares with one idle cycle
        @(negedge clk);
        in1 = 16'hFFFF; in2 = 16'hFFFE; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_flags("b2b.acc", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            wait_done(n);
            check("b2b.lat", n, 4);
            check_flags("b2b.done", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            @(posedge clk); #1;
            check_flags("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check_flags("final", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_comp.md
SERIAL_COMP -- requirements
Module: serial_comp

Interface
REQ-001 Parameter bits, default 16, operand width in bits.
REQ-002 Parameter chunk, default 4, bits compared per clock; bits SHALL be an integer multiple of chunk, else elaboration SHALL fail with $error.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; SHALL be sampled only in IDLE.
REQ-006 in1  input  bits  operand A; SHALL be captured on start acceptance.
REQ-007 in2  input  bits  operand B; SHALL be captured on start acceptance.
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 done  output  1  one-cycle pulse, high in DONE.
REQ-010 Lt  output  1  registered result in1 < in2.
REQ-011 Gt  output  1  registered result in1 > in2.
REQ-012 Et  output  1  registered result in1 == in2.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE; DONE SHALL return to IDLE after one cycle unconditionally.
REQ-014 IDLE with start=1 at an edge SHALL capture in1/in2, clear Lt/Gt/Et to 0, load chunk index to bits/chunk-1 and enter RUN.
REQ-015 RUN SHALL compare one chunk per edge, MSB chunk first, as unsigned chunk-bit values.
REQ-016 Chunks unequal at the current index: SHALL set Lt or Gt accordingly and enter DONE (early termination).
REQ-017 Chunks equal and index is 0: SHALL set Et=1 and enter DONE; chunks equal and index > 0: SHALL decrement the index and stay in RUN.
REQ-018 Exactly one of Lt/Gt/Et SHALL be 1 from DONE until the next accepted start; all three SHALL be 0 while RUN.
REQ-019 Latency: done SHALL be high in the cycle after m edges following the accepting edge, m = chunks examined, 1 <= m <= bits/chunk.
REQ-020 start while busy=1 SHALL be ignored, with no effect on operands or results.
REQ-021 start held high through DONE SHALL be accepted on the first IDLE edge, giving back-to-back operation with one idle cycle.
REQ-022 in1/in2 changes after acceptance SHALL NOT affect the current result.
REQ-023 chunk == bits SHALL give single-cycle compare (m = 1 always).

Reset
REQ-024 rst=1 SHALL immediately force IDLE, busy=0, done=0, Lt=0, Gt=0, Et=0, index=0 and operand registers=0, without waiting for clk.
REQ-025 rst asserted mid-RUN SHALL abort the compare with no done pulse; the first start after rst release SHALL be accepted normally.

Configuration
REQ-026 Macro SERIAL_COMP_SIGNED_EN defined: input port sgn (1 bit) SHALL exist, be captured with start, and sgn=1 SHALL compare operands as two's complement by inverting the MSB of both operands in the top chunk only.
REQ-027 Macro SERIAL_COMP_SIGNED_EN undefined: port sgn SHALL NOT exist; comparison SHALL be unsigned only.

Verification (bits=16, chunk=4)
REQ-028 in1=16'h1234, in2=16'h1234, start pulse -> done after 4 edges, Et=1, Lt=Gt=0.
REQ-029 in1=16'h8000, in2=16'h7FFF, unsigned -> done after 1 edge, Gt=1; with SERIAL_COMP_SIGNED_EN and sgn=1 -> Lt=1.
REQ-030 in1=16'h12A4, in2=16'h12B4 -> done after 3 edges, Lt=1; in1 changed to 16'hFFFF during RUN -> result unchanged.
REQ-031 start re-pulsed during RUN with new operands -> ignored, original result and latency kept.
REQ-032 rst asserted mid-RUN of a 4-chunk equal compare -> outputs 0 immediately, no done pulse; next compare of 16'h0000 vs 16'h0001 -> Lt=1 after 4 edges.
REQ-033 start held high for 3 compares (16'hFFFF vs 16'hFFFE) -> three done pulses, each Gt=1 after 4 edges, one IDLE cycle between compares.
